// File: rtl/calendar_set_ctrl.sv
// Set-mode sequencer for the calendar counter chain: turns MODE/UP key presses into
// field selection, one-hot increment pulses, blink, inactivity timeout and commit.
module calendar_set_ctrl #(
    parameter int unsigned NUM_FIELDS = 5,
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned TIMEOUT_S  = 30
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mode_key,
    input  logic                  up_key,
    input  logic                  tick_1hz,
    output logic                  set_mode,
    output logic [SEL_W-1:0]      field_sel,
    output logic [NUM_FIELDS-1:0] field_up,
    output logic                  blank,
    output logic                  commit
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_S + 1);

    typedef enum logic [1:0] {
        StRun,
        StEdit,
        StCommit
    } state_e;

    // Inputs are sampled once, then compared with their previous sample for edge detect.
    logic mode_s_q, up_s_q, tick_s_q;
    logic mode_h_q, up_h_q;
    logic mode_press, up_press;

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              phase_q, phase_d;
    logic              up_fire;

    logic                  set_mode_d;
    logic [SEL_W-1:0]      field_sel_d;
    logic [NUM_FIELDS-1:0] field_up_d;
    logic                  blank_d;
    logic                  commit_d;

    assign mode_press = mode_s_q & ~mode_h_q;
    assign up_press   = up_s_q & ~up_h_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_s_q  <= 1'b0;
            up_s_q    <= 1'b0;
            tick_s_q  <= 1'b0;
            mode_h_q  <= 1'b0;
            up_h_q    <= 1'b0;
            state_q   <= StRun;
            sel_q     <= '0;
            idle_q    <= '0;
            phase_q   <= 1'b0;
            set_mode  <= 1'b0;
            field_sel <= '0;
            field_up  <= '0;
            blank     <= 1'b0;
            commit    <= 1'b0;
        end else begin
            mode_s_q  <= mode_key;
            up_s_q    <= up_key;
            tick_s_q  <= tick_1hz;
            mode_h_q  <= mode_s_q;
            up_h_q    <= up_s_q;
            state_q   <= state_d;
            sel_q     <= sel_d;
            idle_q    <= idle_d;
            phase_q   <= phase_d;
            set_mode  <= set_mode_d;
            field_sel <= field_sel_d;
            field_up  <= field_up_d;
            blank     <= blank_d;
            commit    <= commit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        idle_d  = idle_q;
        phase_d = phase_q;
        up_fire = 1'b0;
        case (state_q)
            StRun: begin
                if (mode_press) begin
                    state_d = StEdit;
                    sel_d   = '0;
                    idle_d  = '0;
                    phase_d = 1'b0;
                end
            end
            StEdit: begin
                // Mode beats up, and any press beats a coincident tick.
                if (mode_press) begin
                    idle_d  = '0;
                    phase_d = 1'b0;
                    if (sel_q == SEL_W'(NUM_FIELDS - 1)) begin
                        state_d = StCommit;
                        sel_d   = '0;
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                    end
                end else if (up_press) begin
                    up_fire = 1'b1;
                    idle_d  = '0;
                    phase_d = 1'b0;
                end else if (tick_s_q) begin
                    phase_d = ~phase_q;
                    if (idle_q != IDLE_W'(TIMEOUT_S)) begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                    if (idle_q >= IDLE_W'(TIMEOUT_S - 1)) begin
                        state_d = StCommit;
                        sel_d   = '0;
                    end
                end
            end
            StCommit: begin
                state_d = StRun;
                sel_d   = '0;
                idle_d  = '0;
                phase_d = 1'b0;
            end
            default: begin
                state_d = StRun;
                sel_d   = '0;
                idle_d  = '0;
                phase_d = 1'b0;
            end
        endcase
    end

    // Outputs are derived from the next state so they register on the same edge.
    always_comb begin
        set_mode_d  = (state_d == StEdit);
        field_sel_d = (state_d == StEdit) ? sel_d : '0;
        field_up_d  = up_fire ? (NUM_FIELDS'(1) << sel_q) : '0;
        blank_d     = (state_d == StEdit) & phase_d;
        commit_d    = (state_d == StCommit);
    end

endmodule

// File: tb/tb_calendar_set_ctrl.sv
// Bench for calendar_set_ctrl: directed vector table, hand sequences for timeout and
// held keys, then random stimulus checked against a cycle-level behavioural model.
module tb_calendar_set_ctrl;

    localparam int NF = 5;
    localparam int SW = 3;
    localparam int TO = 30;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          mode_key = 1'b0;
    logic          up_key = 1'b0;
    logic          tick_1hz = 1'b0;
    logic          set_mode;
    logic [SW-1:0] field_sel;
    logic [NF-1:0] field_up;
    logic          blank;
    logic          commit;

    calendar_set_ctrl #(
        .NUM_FIELDS(NF),
        .SEL_W     (SW),
        .TIMEOUT_S (TO)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .mode_key (mode_key),
        .up_key   (up_key),
        .tick_1hz (tick_1hz),
        .set_mode (set_mode),
        .field_sel(field_sel),
        .field_up (field_up),
        .blank    (blank),
        .commit   (commit)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0=run, 1=edit, 2=commit cycle.
    int m_state, m_sel, m_idle, m_up_bit;
    bit m_phase;
    bit s_mode, s_up, s_tick, h_mode, h_up;

    function automatic void model_clock(input bit r, input bit m, input bit u, input bit t);
        bit mp, upp;
        if (r) begin
            m_state = 0; m_sel = 0; m_idle = 0; m_phase = 0; m_up_bit = -1;
            s_mode = 0; s_up = 0; s_tick = 0; h_mode = 0; h_up = 0;
            return;
        end
        mp  = s_mode && !h_mode;
        upp = s_up && !h_up;
        m_up_bit = -1;
        if (m_state == 2) begin
            m_state = 0;
        end else if (m_state == 0) begin
            if (mp) begin
                m_state = 1; m_sel = 0; m_idle = 0; m_phase = 0;
            end
        end else begin
            if (mp) begin
                m_idle = 0; m_phase = 0;
                if (m_sel == NF - 1) begin
                    m_state = 2; m_sel = 0;
                end else begin
                    m_sel++;
                end
            end else if (upp) begin
                m_up_bit = m_sel; m_idle = 0; m_phase = 0;
            end else if (s_tick) begin
                m_phase = !m_phase;
                if (m_idle < TO) m_idle++;
                if (m_idle >= TO) begin
                    m_state = 2; m_sel = 0;
                end
            end
        end
        h_mode = s_mode; h_up = s_up;
        s_mode = m; s_up = u; s_tick = t;
    endfunction

    int commits_seen;
    int up_pulses;
    int last_up_val;
    int blank_edges;
    logic blank_prev;

    task automatic step(input bit r, input bit m, input bit u, input bit t, input string tag);
        reset = r; mode_key = m; up_key = u; tick_1hz = t;
        @(posedge clock);
        model_clock(r, m, u, t);
        #1;
        chk({tag, "_set_mode"}, int'(set_mode), int'(m_state == 1));
        chk({tag, "_field_sel"}, int'(field_sel), (m_state == 1) ? m_sel : 0);
        chk({tag, "_field_up"}, int'(field_up), (m_up_bit >= 0) ? (1 << m_up_bit) : 0);
        chk({tag, "_blank"}, int'(blank), int'(m_state == 1 && m_phase));
        chk({tag, "_commit"}, int'(commit), int'(m_state == 2));
        if (commit) commits_seen++;
        if (field_up != '0) begin
            up_pulses++;
            last_up_val = int'(field_up);
        end
        if (blank !== blank_prev) blank_edges++;
        blank_prev = blank;
    endtask

    task automatic press_mode(input string tag);
        step(0, 1, 0, 0, tag);
        step(0, 0, 0, 0, tag);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, "rst");
        step(0, 0, 0, 0, "rst");
        commits_seen = 0; up_pulses = 0; last_up_val = 0; blank_edges = 0;
        blank_prev = blank;
    endtask

    typedef struct {
        bit   rst, mode, up, tick;
        bit   sm;
        int   sel;
        int   fu;
        bit   bl, cm;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit m, input bit u, input bit t, input bit sm,
                       input int sel, input int fu, input bit bl, input bit cm);
        vec_t v;
        v.rst = r; v.mode = m; v.up = u; v.tick = t;
        v.sm = sm; v.sel = sel; v.fu = fu; v.bl = bl; v.cm = cm;
        tbl.push_back(v);
    endtask

    initial begin
        // rst mode up tick | set_mode sel field_up blank commit
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 1, 0, 1, 1, 0, 0, 0);
        add(0, 0, 1, 0, 1, 1, 2, 0, 0);
        add(0, 0, 1, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 1, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 2, 0, 0, 0);
        add(0, 1, 1, 0, 1, 2, 0, 0, 0);
        add(0, 0, 0, 0, 1, 3, 0, 0, 0);
        add(0, 0, 0, 0, 1, 3, 0, 0, 0);
        add(0, 0, 0, 1, 1, 3, 0, 0, 0);
        add(0, 0, 0, 0, 1, 3, 0, 1, 0);
        add(0, 0, 0, 1, 1, 3, 0, 1, 0);
        add(0, 0, 0, 0, 1, 3, 0, 0, 0);
        add(0, 0, 0, 1, 1, 3, 0, 0, 0);
        add(0, 0, 1, 1, 1, 3, 0, 1, 0);
        add(0, 0, 0, 0, 1, 3, 8, 0, 0);
        add(0, 0, 0, 0, 1, 3, 0, 0, 0);
        add(0, 1, 0, 0, 1, 3, 0, 0, 0);
        add(0, 0, 0, 0, 1, 4, 0, 0, 0);
        add(0, 1, 0, 0, 1, 4, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 1, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 2, 0, 0, 0);
        add(0, 1, 0, 0, 1, 2, 0, 0, 0);
        add(0, 0, 0, 0, 1, 3, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clock);
        for (int i = 0; i < tbl.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            reset = tbl[i].rst; mode_key = tbl[i].mode; up_key = tbl[i].up;
            tick_1hz = tbl[i].tick;
            @(posedge clock);
            model_clock(tbl[i].rst, tbl[i].mode, tbl[i].up, tbl[i].tick);
            #1;
            chk({tag, "_set_mode"}, int'(set_mode), int'(tbl[i].sm));
            chk({tag, "_field_sel"}, int'(field_sel), tbl[i].sel);
            chk({tag, "_field_up"}, int'(field_up), tbl[i].fu);
            chk({tag, "_blank"}, int'(blank), int'(tbl[i].bl));
            chk({tag, "_commit"}, int'(commit), int'(tbl[i].cm));
        end

        // Held UP key on field 1 gives a single pulse.
        do_reset();
        press_mode("hold");
        press_mode("hold");
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0, "hold");
        step(0, 0, 0, 0, "hold");
        step(0, 0, 0, 0, "hold");
        chk("hold_up_pulses", up_pulses, 1);
        chk("hold_up_value", last_up_val, 2);

        // Thirty idle ticks force a commit.
        do_reset();
        press_mode("tmo");
        for (int i = 0; i < TO; i++) begin
            step(0, 0, 0, 1, "tmo");
            step(0, 0, 0, 0, "tmo");
        end
        step(0, 0, 0, 0, "tmo");
        chk("timeout_commits", commits_seen, 1);
        chk("timeout_set_mode", int'(set_mode), 0);

        // 29 ticks, an UP press, 29 ticks: still editing, blink toggling each tick.
        do_reset();
        press_mode("keep");
        blank_edges = 0;
        blank_prev = blank;
        for (int i = 0; i < TO - 1; i++) begin
            step(0, 0, 0, 1, "keep");
            step(0, 0, 0, 0, "keep");
        end
        step(0, 0, 1, 0, "keep");
        step(0, 0, 0, 0, "keep");
        for (int i = 0; i < TO - 1; i++) begin
            step(0, 0, 0, 1, "keep");
            step(0, 0, 0, 0, "keep");
        end
        step(0, 0, 0, 0, "keep");
        chk("keep_commits", commits_seen, 0);
        chk("keep_set_mode", int'(set_mode), 1);
        chk("keep_blank_edges", blank_edges, 2 * (TO - 1) + 1);

        // Random stimulus in segments of varying key density.
        do_reset();
        for (int seg = 0; seg < 8; seg++) begin
            int pkey;
            bit m, u, t, r;
            pkey = (seg % 3 == 0) ? 5 : ((seg % 3 == 1) ? 30 : 250);
            m = 0; u = 0;
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, pkey - 1) == 0) m = !m;
                if ($urandom_range(0, pkey - 1) == 0) u = !u;
                t = ($urandom_range(0, 2) == 0);
                r = ($urandom_range(0, 599) == 0);
                step(r, m, u, t, "rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
